// File: rtl/dds_sweep_ctrl.sv
// Purpose: steps a DDS frequency word from f_start toward f_stop (single, sawtooth or triangle sweep).
// Latency: an accepted start shows K=f_start one cycle later; each K value is held dwell+1 cycles.
// Backpressure: none; start is only sampled in IDLE, and abort ends a sweep on the next edge.
module dds_sweep_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [1:0]  mode,
  input  logic [31:0] f_start,
  input  logic [31:0] f_stop,
  input  logic [31:0] f_step,
  input  logic [15:0] dwell,
  input  logic [10:0] phase_cfg,
  output logic [31:0] K,
  output logic [10:0] P,
  output logic        busy,
  output logic        done,
  output logic        sweep_wrap,
  output logic        cfg_err
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  state_t      state, state_n;
  logic [31:0] k_n;
  logic [10:0] p_n;
  logic        busy_n, done_n, wrap_n, err_n;
  logic        dir_up, dir_up_n;
  logic [15:0] dwell_cnt, dwell_cnt_n;

  // Sweep settings captured at an accepted start, so later input changes do not matter
  logic [31:0] start_r, stop_r, step_r;
  logic [15:0] dwell_r;
  logic [1:0]  mode_r;
  logic [31:0] start_r_n, stop_r_n, step_r_n;
  logic [15:0] dwell_r_n;
  logic [1:0]  mode_r_n;

  // Endpoint tests use 33 bits so a 32-bit overflow is never mistaken for a legal step
  logic [32:0] up_sum, dn_lim;
  logic        up_ok, dn_ok;
  logic [31:0] k_dn;
  logic        is_saw, is_tri;

  assign up_sum = {1'b0, K} + {1'b0, step_r};
  assign dn_lim = {1'b0, start_r} + {1'b0, step_r};
  assign up_ok  = (up_sum <= {1'b0, stop_r});
  assign dn_ok  = ({1'b0, K} >= dn_lim);
  assign k_dn   = K - step_r;
  assign is_saw = (mode_r == 2'b01);
  assign is_tri = (mode_r == 2'b10);

  // Next-state and next-output logic; every output is registered below
  always_comb begin
    state_n     = state;
    k_n         = K;
    p_n         = P;
    busy_n      = busy;
    done_n      = 1'b0;
    wrap_n      = 1'b0;
    err_n       = 1'b0;
    dir_up_n    = dir_up;
    dwell_cnt_n = dwell_cnt;
    start_r_n   = start_r;
    stop_r_n    = stop_r;
    step_r_n    = step_r;
    dwell_r_n   = dwell_r;
    mode_r_n    = mode_r;

    case (state)
      ST_IDLE: begin
        busy_n = 1'b0;
        if (start) begin
          if (f_step == 32'd0 || f_start > f_stop) begin
            err_n = 1'b1;
          end else begin
            start_r_n   = f_start;
            stop_r_n    = f_stop;
            step_r_n    = f_step;
            dwell_r_n   = dwell;
            mode_r_n    = mode;
            k_n         = f_start;
            p_n         = phase_cfg;
            busy_n      = 1'b1;
            dwell_cnt_n = dwell;
            dir_up_n    = 1'b1;
            state_n     = ST_RUN;
          end
        end
      end

      ST_RUN: begin
        if (abort) begin
          state_n = ST_IDLE;
          k_n     = 32'd0;
          busy_n  = 1'b0;
        end else if (dwell_cnt != 16'd0) begin
          dwell_cnt_n = dwell_cnt - 16'd1;
        end else begin
          dwell_cnt_n = dwell_r;
          if (dir_up) begin
            if (up_ok) begin
              k_n = up_sum[31:0];
            end else if (is_saw) begin
              k_n    = start_r;
              wrap_n = 1'b1;
            end else if (is_tri) begin
              dir_up_n = 1'b0;
              wrap_n   = 1'b1;
              if (dn_ok) k_n = k_dn;
            end else begin
              // single sweep (mode 00 or 11): finish, K keeps its last value
              state_n = ST_DONE;
              busy_n  = 1'b0;
              done_n  = 1'b1;
            end
          end else begin
            // only a triangle sweep ever travels downward
            if (dn_ok) begin
              k_n = k_dn;
            end else begin
              dir_up_n = 1'b1;
              wrap_n   = 1'b1;
              if (up_ok) k_n = up_sum[31:0];
            end
          end
        end
      end

      ST_DONE: begin
        state_n = ST_IDLE;
        busy_n  = 1'b0;
        if (abort) k_n = 32'd0;
      end

      default: begin
        state_n = ST_IDLE;
        busy_n  = 1'b0;
      end
    endcase
  end

  // State, outputs and captured settings; reset overrides start and abort
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      K          <= 32'd0;
      P          <= 11'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      sweep_wrap <= 1'b0;
      cfg_err    <= 1'b0;
      dir_up     <= 1'b1;
      dwell_cnt  <= 16'd0;
      start_r    <= 32'd0;
      stop_r     <= 32'd0;
      step_r     <= 32'd0;
      dwell_r    <= 16'd0;
      mode_r     <= 2'b00;
    end else begin
      state      <= state_n;
      K          <= k_n;
      P          <= p_n;
      busy       <= busy_n;
      done       <= done_n;
      sweep_wrap <= wrap_n;
      cfg_err    <= err_n;
      dir_up     <= dir_up_n;
      dwell_cnt  <= dwell_cnt_n;
      start_r    <= start_r_n;
      stop_r     <= stop_r_n;
      step_r     <= step_r_n;
      dwell_r    <= dwell_r_n;
      mode_r     <= mode_r_n;
    end
  end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Bench for dds_sweep_ctrl: directed sweeps with hand-computed cycle-by-cycle outputs.
// Expected outputs are queued against a cycle stamp; a negedge monitor pops and compares.
// No backpressure; every wait is bounded by a cycle budget.
module tb_dds_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [1:0]  mode;
  logic [31:0] f_start, f_stop, f_step;
  logic [15:0] dwell;
  logic [10:0] phase_cfg;
  logic [31:0] K;
  logic [10:0] P;
  logic        busy, done, sweep_wrap, cfg_err;

  dds_sweep_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .mode(mode),
    .f_start(f_start), .f_stop(f_stop), .f_step(f_step), .dwell(dwell),
    .phase_cfg(phase_cfg), .K(K), .P(P), .busy(busy), .done(done),
    .sweep_wrap(sweep_wrap), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [31:0] k;
    logic [10:0] p;
    bit          chk_p;
    bit          busy;
    bit          done;
    bit          wrap;
    bit          err;
    string       tag;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;

  task automatic expect_at(input int c, input logic [31:0] k, input logic [10:0] p,
                           input bit cp, input bit b, input bit d, input bit w,
                           input bit e, input string tag);
    exp_t x;
    x.cyc = c; x.k = k; x.p = p; x.chk_p = cp;
    x.busy = b; x.done = d; x.wrap = w; x.err = e; x.tag = tag;
    sb.push_back(x);
  endtask

  // Monitor: compare every expectation stamped for the current cycle
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      mon_e = sb.pop_front();
      checks++;
      if (mon_e.cyc != cyc || K !== mon_e.k || (mon_e.chk_p && P !== mon_e.p) ||
          busy !== mon_e.busy || done !== mon_e.done ||
          sweep_wrap !== mon_e.wrap || cfg_err !== mon_e.err) begin
        errors++;
        $display("FAIL %s cyc=%0d: got K=%h P=%h busy=%b done=%b wrap=%b err=%b; want cyc=%0d K=%h P=%h busy=%b done=%b wrap=%b err=%b",
                 mon_e.tag, cyc, K, P, busy, done, sweep_wrap, cfg_err,
                 mon_e.cyc, mon_e.k, mon_e.p, mon_e.busy, mon_e.done, mon_e.wrap, mon_e.err);
      end
    end
  end

  // Advance to just after the edge that makes cyc equal c
  task automatic at_cyc(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Pulse start for one cycle; base is the first cycle showing the response
  task automatic go(input logic [1:0] m, input logic [31:0] fs, input logic [31:0] fe,
                    input logic [31:0] st, input logic [15:0] dw, input logic [10:0] ph,
                    output int base);
    mode = m; f_start = fs; f_stop = fe; f_step = st; dwell = dw; phase_cfg = ph;
    start = 1'b1;
    base = cyc + 1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  int b;
  logic [31:0] tri_k [8];
  logic        tri_w [8];
  logic [31:0] saw_k [5];
  logic        saw_w [5];

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; mode = 2'b00;
    f_start = '0; f_stop = '0; f_step = '0; dwell = '0; phase_cfg = '0;

    // Reset state
    @(posedge clk); #1;
    @(posedge clk); #1;
    expect_at(cyc, 32'd0, 11'd0, 1, 0, 0, 0, 0, "reset");
    rst = 1'b0;
    expect_at(cyc + 1, 32'd0, 11'd0, 1, 0, 0, 0, 0, "reset_idle");
    at_cyc(cyc + 2);

    // Single 100..130 step 10 dwell 2; inputs scrambled during RUN must not matter
    go(2'b00, 32'd100, 32'd130, 32'd10, 16'd2, 11'h123, b);
    f_start = 32'd5; f_stop = 32'd0; f_step = 32'd1; dwell = 16'd7; mode = 2'b10; phase_cfg = 11'h7FF;
    for (int i = 0; i < 12; i++)
      expect_at(b + i, 32'd100 + 32'd10 * (i / 3), 11'h123, 1, 1, 0, 0, 0, "single_dwell2");
    expect_at(b + 12, 32'd130, 11'h123, 1, 0, 1, 0, 0, "single_done");
    expect_at(b + 13, 32'd130, 11'h123, 1, 0, 0, 0, 0, "single_idle");
    at_cyc(b + 14);

    // Single 100..125: 130 must never appear
    go(2'b00, 32'd100, 32'd125, 32'd10, 16'd0, 11'h000, b);
    expect_at(b + 0, 32'd100, 11'h000, 1, 1, 0, 0, 0, "s125_k0");
    expect_at(b + 1, 32'd110, 11'h000, 1, 1, 0, 0, 0, "s125_k1");
    expect_at(b + 2, 32'd120, 11'h000, 1, 1, 0, 0, 0, "s125_k2");
    expect_at(b + 3, 32'd120, 11'h000, 1, 0, 1, 0, 0, "s125_done");
    expect_at(b + 4, 32'd120, 11'h000, 1, 0, 0, 0, 0, "s125_idle");
    at_cyc(b + 5);

    // Rejected starts: step==0, then start>stop; K/P unchanged
    go(2'b00, 32'd100, 32'd200, 32'd0, 16'd0, 11'h055, b);
    expect_at(b + 0, 32'd120, 11'h000, 1, 0, 0, 0, 1, "err_step0");
    expect_at(b + 1, 32'd120, 11'h000, 1, 0, 0, 0, 0, "err_step0_after");
    at_cyc(b + 1);
    go(2'b00, 32'd200, 32'd100, 32'd10, 16'd0, 11'h066, b);
    expect_at(b + 0, 32'd120, 11'h000, 1, 0, 0, 0, 1, "err_order");
    expect_at(b + 1, 32'd120, 11'h000, 1, 0, 0, 0, 0, "err_order_after");
    at_cyc(b + 1);

    // abort in IDLE has no effect
    abort = 1'b1;
    b = cyc + 1;
    expect_at(b, 32'd120, 11'h000, 1, 0, 0, 0, 0, "abort_idle");
    @(posedge clk); #1;
    abort = 1'b0;
    expect_at(b + 1, 32'd120, 11'h000, 1, 0, 0, 0, 0, "abort_idle_after");
    at_cyc(b + 2);

    // mode 11 behaves as single
    go(2'b11, 32'd10, 32'd20, 32'd10, 16'd0, 11'h001, b);
    expect_at(b + 0, 32'd10, 11'h001, 1, 1, 0, 0, 0, "m3_k0");
    expect_at(b + 1, 32'd20, 11'h001, 1, 1, 0, 0, 0, "m3_k1");
    expect_at(b + 2, 32'd20, 11'h001, 1, 0, 1, 0, 0, "m3_done");
    expect_at(b + 3, 32'd20, 11'h001, 1, 0, 0, 0, 0, "m3_idle");
    at_cyc(b + 4);

    // Triangle 100..120 step 10 dwell 0
    tri_k = '{32'd100, 32'd110, 32'd120, 32'd110, 32'd100, 32'd110, 32'd120, 32'd110};
    tri_w = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    go(2'b10, 32'd100, 32'd120, 32'd10, 16'd0, 11'h005, b);
    for (int i = 0; i < 8; i++)
      expect_at(b + i, tri_k[i], 11'h005, 1, 1, 0, tri_w[i], 0, "triangle");
    at_cyc(b + 7);
    abort = 1'b1;
    expect_at(b + 8, 32'd0, 11'h000, 0, 0, 0, 0, 0, "tri_abort");
    @(posedge clk); #1;
    abort = 1'b0;
    expect_at(b + 9, 32'd0, 11'h000, 0, 0, 0, 0, 0, "tri_abort_idle");
    at_cyc(b + 10);

    // Sawtooth, abort (with a start that must be ignored) during second frequency
    go(2'b01, 32'd100, 32'd120, 32'd10, 16'd3, 11'h007, b);
    for (int i = 0; i < 6; i++)
      expect_at(b + i, (i < 4) ? 32'd100 : 32'd110, 11'h007, 1, 1, 0, 0, 0, "saw_run");
    at_cyc(b + 5);
    abort = 1'b1; start = 1'b1; f_start = 32'd1; f_stop = 32'd2; f_step = 32'd1;
    expect_at(b + 6, 32'd0, 11'h000, 0, 0, 0, 0, 0, "saw_abort");
    @(posedge clk); #1;
    abort = 1'b0; start = 1'b0;
    expect_at(b + 7, 32'd0, 11'h000, 0, 0, 0, 0, 0, "saw_abort_idle");
    at_cyc(b + 8);

    // Following valid sawtooth runs normally, including a wrap
    saw_k = '{32'd10, 32'd20, 32'd30, 32'd10, 32'd20};
    saw_w = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    go(2'b01, 32'd10, 32'd30, 32'd10, 16'd0, 11'h009, b);
    for (int i = 0; i < 5; i++)
      expect_at(b + i, saw_k[i], 11'h009, 1, 1, 0, saw_w[i], 0, "saw2");
    at_cyc(b + 4);
    abort = 1'b1;
    expect_at(b + 5, 32'd0, 11'h000, 0, 0, 0, 0, 0, "saw2_abort");
    @(posedge clk); #1;
    abort = 1'b0;
    at_cyc(b + 6);

    // Top of range: K+step overflows 32 bits, must not wrap
    go(2'b00, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h10, 16'd0, 11'h002, b);
    expect_at(b + 0, 32'hFFFF_FFF0, 11'h002, 1, 1, 0, 0, 0, "top_k0");
    expect_at(b + 1, 32'hFFFF_FFF0, 11'h002, 1, 0, 1, 0, 0, "top_done");
    expect_at(b + 2, 32'hFFFF_FFF0, 11'h002, 1, 0, 0, 0, 0, "top_idle");
    at_cyc(b + 3);

    // Reset mid-RUN together with start and abort
    go(2'b00, 32'd100, 32'd130, 32'd10, 16'd2, 11'h003, b);
    for (int i = 0; i < 4; i++)
      expect_at(b + i, (i < 3) ? 32'd100 : 32'd110, 11'h003, 1, 1, 0, 0, 0, "rst_run");
    at_cyc(b + 3);
    rst = 1'b1; start = 1'b1; abort = 1'b1;
    expect_at(b + 4, 32'd0, 11'd0, 1, 0, 0, 0, 0, "rst_mid");
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0; abort = 1'b0;
    expect_at(b + 5, 32'd0, 11'd0, 1, 0, 0, 0, 0, "rst_mid_idle");
    expect_at(b + 6, 32'd0, 11'd0, 1, 0, 0, 0, 0, "rst_mid_idle2");
    at_cyc(b + 7);

    // Drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 10 && sb.size() > 0; i++) begin
      @(posedge clk); #1;
    end
    if (sb.size() > 0) begin
      errors++;
      checks++;
      $display("FAIL drain: %0d expectations never compared, want 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog");
  end

endmodule
